uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Receives one 8N1 UART byte from the serial line and presents it as a parallel byte with a one-cycle done strobe. It is the receive-side counterpart of the team's byte transmitter and shares its 50 MHz system clock and 3-bit baud selection. The block uses 16x oversampling, majority-vote bit sampling, false-start rejection and stop-bit checking. Output goes to downstream command/loopback logic.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz; sets oversample divider values.
- Clk  input  1  system clock, 50 MHz.
- Reset_n  input  1  reset; asynchronous, active-low.
- baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5–7 behave as 0.
- uart_rx  input  1  asynchronous serial line; idle high.
- Data  output  8  last received byte, LSB first on line.
- rx_done  output  1  one-cycle pulse: Data valid, frame good.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high while a frame is in progress (state != IDLE).

## Operation
- Input synchronizer: uart_rx passes through a 2-FF synchronizer (reset value 1), then a third register for edge detect.
- Start edge: registered falling edge, previous=1 and current=0, detected in IDLE only.
- Divider: DIV = CLK_FREQ/(baud*16), integer truncated. Values are 325, 162, 81, 54, 27 for selects 0–4.
  - baud_set is latched on the start edge and held constant for the whole frame.
- div_cnt: 0 in IDLE. Cleared on the start edge. Counts 0..DIV-1 and wraps. A sample tick is generated when div_cnt == DIV-1.
- samp_cnt (4-bit): counts ticks within a bit, 0..15, then wraps. On wrap, bit_cnt increments.
- Bit value: majority of the synchronized samples taken at samp_cnt 7, 8 and 9. It is evaluated on the tick where samp_cnt == 9.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on start edge.
  - START: at evaluation, majority 1 -> IDLE (false start, no output). Majority 0 -> continue; on samp_cnt wrap -> DATA with bit_cnt = 0.
  - DATA: at evaluation, shift the bit into shift register bit[bit_cnt] (LSB first). After bit_cnt 7 wraps -> STOP.
  - STOP: at evaluation, Data <= shift register and the FSM returns to IDLE immediately, in mid-stop-bit, for resync margin. Majority 1 -> rx_done pulse; majority 0 -> frame_err pulse.
- Data updates only at STOP evaluation, on both good and errored frames. It holds otherwise.
- rx_done and frame_err are never high together.
- A line low in IDLE after a frame error with no new falling edge (break condition) does not start a frame until the line returns high and then falls.

## Timing
- Reset values: Data=8'h00, rx_done=0, frame_err=0, busy=0, FSM=IDLE, all counters 0.
- Reset asserted mid-frame aborts the frame immediately. No pulse is generated and Data keeps its reset value.
- Edge-detect latency: 3 Clk cycles from the uart_rx fall to the start edge registering (busy rises the next cycle).
- Start-bit evaluation: 10*DIV cycles after the start edge.
- rx_done/frame_err: asserted one Clk cycle after the STOP evaluation tick, which is (9*16+10)*DIV cycles after the start edge. The pulse lasts exactly one cycle.
- Back-to-back frames: a start edge arriving in the second half of the stop bit (i.e. after return to IDLE) is accepted.
- Tolerated baud mismatch: ±3% cumulative over 10 bits with the stated DIV values.

## Test plan
- 115200 (baud_set=4), bit time 434 cycles, send 0x55 -> Data=0x55, one rx_done pulse, frame_err=0, busy low after the pulse.
- 9600 (baud_set=0), send 0x00, then 0xFF, then 0xA3 back-to-back with one stop bit each -> three rx_done pulses, Data sequence 0x00, 0xFF, 0xA3.
- 115200, line low for 100 cycles, then high -> FSM returns to IDLE at start evaluation, no rx_done, no frame_err, Data unchanged.
- 115200, send 0x3C with the stop bit driven low -> frame_err single pulse, rx_done=0, Data=0x3C; after the line goes high then sends 0x81 -> rx_done, Data=0x81.
- 38400, assert Reset_n low during data bit 4 of 0xF0 -> all outputs at reset values, no pulse. After release, 0x5A is received correctly.
- 57600 frame with ±1-cycle glitch on sample 8 of each data bit for 0x96 -> majority vote yields Data=0x96; baud_set changed mid-frame has no effect on the current frame.

Source files
------------

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote,
// false-start rejection and stop-bit check, with selectable baud rate.
`timescale 1ns/1ps
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] Data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] DIV_M1_0 = 16'(CLK_FREQ / (9600 * 16) - 1);
  localparam logic [15:0] DIV_M1_1 = 16'(CLK_FREQ / (19200 * 16) - 1);
  localparam logic [15:0] DIV_M1_2 = 16'(CLK_FREQ / (38400 * 16) - 1);
  localparam logic [15:0] DIV_M1_3 = 16'(CLK_FREQ / (57600 * 16) - 1);
  localparam logic [15:0] DIV_M1_4 = 16'(CLK_FREQ / (115200 * 16) - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic        rx_s1, rx_s2, rx_d;
  logic [2:0]  baud_q;
  logic [15:0] div_cnt;
  logic [15:0] div_lim;
  logic [3:0]  samp_cnt;
  logic [2:0]  bit_cnt;
  logic        s7, s8;
  logic [7:0]  shreg;
  logic        tick;
  logic        start_edge;
  logic        maj;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Divider limit comes from the baud select captured at the start edge,
  // so a change on baud_set never disturbs a frame already in progress.
  always_comb begin
    case (baud_q)
      3'd1:    div_lim = DIV_M1_1;
      3'd2:    div_lim = DIV_M1_2;
      3'd3:    div_lim = DIV_M1_3;
      3'd4:    div_lim = DIV_M1_4;
      default: div_lim = DIV_M1_0;
    endcase
  end

  assign tick       = (div_cnt == div_lim);
  assign start_edge = rx_d & ~rx_s2;
  assign maj        = (s7 & s8) | (s7 & rx_s2) | (s8 & rx_s2);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      baud_q    <= 3'd0;
      div_cnt   <= 16'd0;
      samp_cnt  <= 4'd0;
      bit_cnt   <= 3'd0;
      s7        <= 1'b1;
      s8        <= 1'b1;
      shreg     <= 8'h00;
      Data      <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt  <= 16'd0;
          samp_cnt <= 4'd0;
          bit_cnt  <= 3'd0;
          if (start_edge) begin
            state  <= START;
            busy   <= 1'b1;
            baud_q <= baud_set;
          end
        end
        default: begin
          if (tick) begin
            div_cnt  <= 16'd0;
            samp_cnt <= samp_cnt + 4'd1;
            if (samp_cnt == 4'd7) s7 <= rx_s2;
            if (samp_cnt == 4'd8) s8 <= rx_s2;
          end else begin
            div_cnt <= div_cnt + 16'd1;
          end
          if (tick) begin
            case (state)
              START: begin
                if (samp_cnt == 4'd9 && maj) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else if (samp_cnt == 4'd15) begin
                  state   <= DATA;
                  bit_cnt <= 3'd0;
                end
              end
              DATA: begin
                if (samp_cnt == 4'd9) shreg[bit_cnt] <= maj;
                if (samp_cnt == 4'd15) begin
                  if (bit_cnt == 3'd7) state <= STOP;
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
              // Leave mid-stop-bit so the next start edge can be caught early.
              STOP: begin
                if (samp_cnt == 4'd9) begin
                  Data      <= shreg;
                  rx_done   <= maj;
                  frame_err <= ~maj;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Scoreboard bench for uart_byte_rx: frames are queued as they are driven
// and checked against each rx_done/frame_err pulse.
`timescale 1ns/1ps
module tb_uart_byte_rx;

  // Scaled clock keeps the slow 9600-baud frames short; divisors 65/32/16/10/5.
  localparam int CLK_FREQ = 10_000_000;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [2:0] baud_set = 3'd0;
  logic       uart_rx = 1'b1;
  logic [7:0] Data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t expq[$];
  int   errors = 0;
  int   checks = 0;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .baud_set(baud_set),
    .uart_rx(uart_rx),
    .Data(Data),
    .rx_done(rx_done),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #50 Clk = ~Clk;

  function automatic int divFor(input int sel);
    case (sel)
      1:       return 32;
      2:       return 16;
      3:       return 10;
      4:       return 5;
      default: return 65;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic driveBits(input logic v, input int n);
    repeat (n) begin
      @(negedge Clk);
      uart_rx = v;
    end
  endtask

  // Sends one frame; glitch inverts the line for 3 cycles around sample 8 of each data bit.
  task automatic applyStimulus(input logic [7:0] b, input int sel, input logic stopBit, input logic glitch);
    int   div;
    int   bt;
    exp_t e;
    logic v;
    div = divFor(sel);
    bt  = 16 * div;
    baud_set = 3'(sel);
    e.kind = stopBit ? 2'b10 : 2'b01;
    e.data = b;
    expq.push_back(e);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      v = 1'b0;
      else if (i == 9) v = stopBit;
      else             v = b[i-1];
      for (int c = 0; c < bt; c++) begin
        @(negedge Clk);
        if (glitch && i >= 1 && i <= 8 && c >= 9*div - 1 && c <= 9*div + 1)
          uart_rx = ~v;
        else
          uart_rx = v;
      end
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (Reset_n && (rx_done || frame_err)) begin
      if (expq.size() == 0) begin
        checkOutput("unexpected_pulse", {22'd0, rx_done, frame_err, Data}, 32'd0);
      end else begin
        e = expq.pop_front();
        checkOutput("pulse_kind", {30'd0, rx_done, frame_err}, {30'd0, e.kind});
        checkOutput("rx_data", {24'd0, Data}, {24'd0, e.data});
        checkOutput("busy_after_pulse", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #8_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (5) @(negedge Clk);
    checkOutput("reset_data", {24'd0, Data}, 32'h00);
    checkOutput("reset_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("reset_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    Reset_n = 1'b1;
    driveBits(1'b1, 20);

    applyStimulus(8'h55, 4, 1'b1, 1'b0);
    driveBits(1'b1, 160);
    checkOutput("pending_t1", 32'(expq.size()), 32'd0);

    applyStimulus(8'h00, 0, 1'b1, 1'b0);
    applyStimulus(8'hFF, 0, 1'b1, 1'b0);
    applyStimulus(8'hA3, 0, 1'b1, 1'b0);
    driveBits(1'b1, 1000);
    checkOutput("pending_b2b", 32'(expq.size()), 32'd0);

    baud_set = 3'd4;
    driveBits(1'b0, 20);
    checkOutput("false_start_busy", {31'd0, busy}, 32'd1);
    driveBits(1'b1, 200);
    checkOutput("false_start_idle", {31'd0, busy}, 32'd0);
    checkOutput("false_start_data", {24'd0, Data}, 32'hA3);

    applyStimulus(8'h3C, 4, 1'b0, 1'b0);
    driveBits(1'b0, 300);
    checkOutput("break_no_start", {31'd0, busy}, 32'd0);
    driveBits(1'b1, 100);
    applyStimulus(8'h81, 4, 1'b1, 1'b0);
    driveBits(1'b1, 200);
    checkOutput("pending_ferr", 32'(expq.size()), 32'd0);

    baud_set = 3'd2;
    driveBits(1'b0, 256);
    driveBits(1'b0, 4 * 256);
    driveBits(1'b1, 128);
    Reset_n = 1'b0;
    driveBits(1'b1, 10);
    checkOutput("abort_data", {24'd0, Data}, 32'h00);
    checkOutput("abort_rx_done", {31'd0, rx_done}, 32'd0);
    checkOutput("abort_frame_err", {31'd0, frame_err}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    Reset_n = 1'b1;
    driveBits(1'b1, 300);
    applyStimulus(8'h5A, 2, 1'b1, 1'b0);
    driveBits(1'b1, 500);
    checkOutput("pending_abort", 32'(expq.size()), 32'd0);

    fork
      applyStimulus(8'h96, 3, 1'b1, 1'b1);
      begin
        repeat (500) @(negedge Clk);
        baud_set = 3'd4;
      end
    join
    driveBits(1'b1, 400);
    checkOutput("pending_glitch", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
